prog_delay_line: RTL



---
 rtl/prog_delay_line.sv | 94 +++++++++
 1 files changed

// File: rtl/prog_delay_line.sv
// Runtime-programmable, enable-gated delay line: circular buffer of C_MAX_DELAY
// entries, each sample re-emitted exactly D enabled ticks after it was written.
module prog_delay_line #(
  parameter int unsigned C_DATA_WIDTH    = 310,
  parameter int unsigned C_MAX_DELAY     = 16,
  parameter int unsigned C_DEFAULT_DELAY = 5,
  parameter int unsigned C_CFG_W         = $clog2(C_MAX_DELAY + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [C_DATA_WIDTH-1:0] data_in,
  input  logic                    valid_in,
  input  logic                    cfg_wr,
  input  logic [C_CFG_W-1:0]      cfg_delay,
  output logic [C_DATA_WIDTH-1:0] data_out,
  output logic                    valid_out,
  output logic [C_CFG_W-1:0]      cur_delay,
  output logic                    primed
);

  localparam int unsigned PTR_W = (C_MAX_DELAY > 1) ? $clog2(C_MAX_DELAY) : 1;

  logic [C_DATA_WIDTH-1:0] mem [C_MAX_DELAY];
  logic [C_MAX_DELAY-1:0]  vflags;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        wr_ptr_nxt;
  logic [PTR_W-1:0]        rd_ptr;
  logic [C_CFG_W-1:0]      fill_cnt;
  logic [C_CFG_W-1:0]      cfg_clamped;
  logic                    tick;

  logic [C_CFG_W:0] back;
  logic [C_CFG_W:0] wr_ext;
  logic [C_CFG_W:0] rd_ext;

  assign tick   = en & ~reset & ~cfg_wr;
  assign primed = (fill_cnt == cur_delay);

  // Read index = (wr_ptr - (D-1)) mod depth; explicit wrap keeps it correct
  // for depths that are not a power of two.
  always_comb begin
    back   = (C_CFG_W + 1)'(cur_delay) - (C_CFG_W + 1)'(1);
    wr_ext = (C_CFG_W + 1)'(wr_ptr);
    if (wr_ext >= back) rd_ext = wr_ext - back;
    else                rd_ext = wr_ext + (C_CFG_W + 1)'(C_MAX_DELAY) - back;
    rd_ptr = rd_ext[PTR_W-1:0];
  end

  always_comb begin
    if (wr_ptr == PTR_W'(C_MAX_DELAY - 1)) wr_ptr_nxt = '0;
    else                                   wr_ptr_nxt = wr_ptr + PTR_W'(1);
  end

  always_comb begin
    if (cfg_delay == '0)                          cfg_clamped = C_CFG_W'(1);
    else if (cfg_delay > C_CFG_W'(C_MAX_DELAY))   cfg_clamped = C_CFG_W'(C_MAX_DELAY);
    else                                          cfg_clamped = cfg_delay;
  end

  // Data storage: plain RAM, never cleared.
  always_ff @(posedge clk) begin
    if (tick) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      vflags    <= '0;
      fill_cnt  <= '0;
      cur_delay <= C_CFG_W'(C_DEFAULT_DELAY);
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (cfg_wr) begin
      cur_delay <= cfg_clamped;
      vflags    <= '0;
      fill_cnt  <= '0;
      valid_out <= 1'b0;
    end else if (en) begin
      vflags[wr_ptr] <= valid_in;
      wr_ptr         <= wr_ptr_nxt;
      if (fill_cnt != cur_delay) fill_cnt <= fill_cnt + C_CFG_W'(1);
      // Same-address read (D=1) sees this tick's write.
      if (rd_ptr == wr_ptr) begin
        data_out  <= data_in;
        valid_out <= valid_in;
      end else begin
        data_out  <= mem[rd_ptr];
        valid_out <= vflags[rd_ptr];
      end
    end
  end

endmodule
